// File: rtl/injection_scheduler.sv
// Throttled, credit-controlled round-robin injection of NUM_REQ packet sources onto one router channel.
// Optional INJECTION_SCHEDULER_STATS_EN adds inject_count / blocked_count outputs.
module injection_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int CHANNEL_WIDTH = 64,
   parameter int BUFFER_DEPTH  = 4,
   parameter int CREDIT_WIDTH  = 3
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   input  logic [3:0]                         traffic_rate,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*CHANNEL_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                 req_ack,
   input  logic                               credit_in,
   output logic [CHANNEL_WIDTH-1:0]           channel_dout,
   output logic                               channel_valid,
   output logic                               stall
`ifdef INJECTION_SCHEDULER_STATS_EN
   ,
   output logic [31:0]                        inject_count,
   output logic [31:0]                        blocked_count
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_STALL} state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 slot_q, slot_d;
   logic [CREDIT_WIDTH-1:0]    credits_q, credits_d;
   logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic [CHANNEL_WIDTH-1:0]   dout_q, dout_d;
   logic                       valid_q, valid_d;
   logic                       stall_q, stall_d;

   logic [3:0]                 rate_eff;
   logic                       slot_open, any_req, grant_ok, found;
   logic [PTR_W-1:0]           grant_idx;
   int                         idx;

   always_comb begin
      rate_eff  = (traffic_rate > 4'd10) ? 4'd10 : traffic_rate;
      slot_open = slot_q < rate_eff;
      any_req   = |req_valid;
      // reset gates grants so no requester believes its packet was taken on a reset edge
      grant_ok  = !reset && enable && (state_q == ST_ACTIVE) && slot_open &&
                  (credits_q != '0) && any_req;

      found     = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found     = 1'b1;
            grant_idx = PTR_W'(idx);
         end
      end

      req_ack = '0;
      if (grant_ok) req_ack[grant_idx] = 1'b1;

      rr_ptr_d = rr_ptr_q;
      if (grant_ok)
         rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

      credits_d = credits_q;
      if (grant_ok && !credit_in)
         credits_d = credits_q - 1'b1;
      else if (!grant_ok && credit_in && (credits_q != CREDIT_WIDTH'(BUFFER_DEPTH)))
         credits_d = credits_q + 1'b1;

      if (state_q == ST_IDLE)   slot_d = 4'd0;
      else if (slot_q == 4'd9)  slot_d = 4'd0;
      else                      slot_d = slot_q + 4'd1;

      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (enable) state_d = ST_ACTIVE;
         ST_ACTIVE: begin
            if (!enable) state_d = ST_IDLE;
            // a credit arriving this cycle is enough to keep going without a stall round trip
            else if ((credits_q == '0) && !credit_in && any_req) state_d = ST_STALL;
         end
         ST_STALL: begin
            if (!enable)        state_d = ST_IDLE;
            else if (credit_in) state_d = ST_ACTIVE;
         end
         default:   state_d = ST_IDLE;
      endcase

      dout_d  = grant_ok ? req_data[grant_idx*CHANNEL_WIDTH +: CHANNEL_WIDTH] : dout_q;
      valid_d = grant_ok;
      stall_d = (state_d == ST_STALL) && any_req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         slot_q    <= 4'd0;
         credits_q <= CREDIT_WIDTH'(BUFFER_DEPTH);
         rr_ptr_q  <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         stall_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         credits_q <= credits_d;
         rr_ptr_q  <= rr_ptr_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         stall_q   <= stall_d;
      end
   end

   assign channel_dout  = dout_q;
   assign channel_valid = valid_q;
   assign stall         = stall_q;

`ifdef INJECTION_SCHEDULER_STATS_EN
   logic [31:0] inject_count_q, inject_count_d;
   logic [31:0] blocked_count_q, blocked_count_d;

   always_comb begin
      inject_count_d  = grant_ok ? inject_count_q + 32'd1 : inject_count_q;
      blocked_count_d = blocked_count_q;
      if (any_req && (state_q != ST_IDLE) && !grant_ok && (blocked_count_q != '1))
         blocked_count_d = blocked_count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inject_count_q  <= '0;
         blocked_count_q <= '0;
      end else begin
         inject_count_q  <= inject_count_d;
         blocked_count_q <= blocked_count_d;
      end
   end

   assign inject_count  = inject_count_q;
   assign blocked_count = blocked_count_q;
`endif

endmodule

// File: doc/injection_scheduler.md
Name: injection_scheduler

Overview:
- Shares one network-core injection port (x- or x+ edge) among NUM_REQ local packet requesters, e.g. test_engine outputs or packet sources.
- Enforces three conditions before any packet is injected:
  - a programmable duty cycle (traffic_rate of 10 slots);
  - credit-based flow control toward the edge router input buffer;
  - round-robin fairness between requesters.
- Sits between the requesters and the router channel input.
- Lets benches and SoC glue inject throttled traffic without per-port logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CHANNEL_WIDTH, 64, packet/flit width in bits (matches the network channel).
- BUFFER_DEPTH, 4, downstream router input buffer depth; initial credit count.
- CREDIT_WIDTH, 3, credit counter width; must hold BUFFER_DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scheduling allowed; 0 = no new grants.
- traffic_rate  in  4  injection slots per 10-cycle window; values >10 treated as 10; 0 blocks injection.
- req_valid  in  NUM_REQ  requester i has a packet pending.
- req_data  in  NUM_REQ*CHANNEL_WIDTH  packet of requester i, at bits [i*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- req_ack  out  NUM_REQ  one-hot, combinational; requester i's packet is consumed at this clock edge.
- credit_in  in  1  one-cycle pulse; router freed one buffer slot.
- channel_dout  out  CHANNEL_WIDTH  registered packet to router.
- channel_valid  out  1  registered; channel_dout is valid this cycle.
- stall  out  1  registered; credits are 0 while at least one requester is pending.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - channel_dout=0, channel_valid=0, stall=0, req_ack=0.
  - credits=BUFFER_DEPTH, slot=0, rr_ptr=0, FSM=IDLE.
  - Reset mid-injection discards the in-flight packet; outstanding credits are forgotten, i.e. the router must be reset together with this block.
- Slot counter:
  - Counts 0..9 and wraps 9->0.
  - Advances every cycle while FSM is not IDLE; held at 0 in IDLE.
  - slot_open = (slot < min(traffic_rate,10)).
- Credits:
  - Decrement on injection; increment on credit_in; both in the same cycle leaves the count unchanged.
  - credit_in while credits==BUFFER_DEPTH is ignored (saturate, no wrap).
  - An injection with credits==0 is impossible by construction.
- Eligibility: grant_ok = FSM==ACTIVE & slot_open & credits>0 & |req_valid.
- Arbitration:
  - Round-robin: search starts at rr_ptr and picks the first asserted req_valid, wrapping NUM_REQ-1 -> 0.
  - On grant to i: req_ack[i]=1 in the same cycle (combinational from registered state and req_valid); rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr is held.
- Datapath:
  - Latency 1: channel_dout <= req_data[i], channel_valid <= 1 on the edge ending the grant cycle.
  - Otherwise channel_valid <= 0 and channel_dout is held.
  - At most one packet per cycle.
- FSM:
  - IDLE: enable=1 -> ACTIVE.
  - ACTIVE: enable=0 -> IDLE. Else credits==0 and a grant is not possible due to credits -> STALL.
  - STALL: no grants; stall=1 while |req_valid. credit_in -> ACTIVE, granting from the next cycle. enable=0 -> IDLE.
  - enable deassert takes effect the same cycle: no grant in that cycle. A packet already registered still presents on channel_valid.
- Requesters must hold req_valid/req_data stable until acked. Dropping req_valid without an ack is legal; no grant is issued to that requester.

Optional Feature:
- Macro INJECTION_SCHEDULER_STATS_EN.
- Defined:
  - adds output inject_count (32-bit): total injections since reset, wraps at 2^32;
  - adds output blocked_count (32-bit): cycles with |req_valid & FSM!=IDLE & no grant, saturating at 2^32-1;
  - both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Fairness: reset, enable=1, traffic_rate=10, all 4 req_valid held high, credit_in pulsed every injection -> grants 0,1,2,3,0,1,... with channel_valid high every cycle from cycle 2 after enable.
- Throttle: traffic_rate=3, one requester always valid, credits replenished -> exactly 3 injections per 10 cycles, occurring on slots 0,1,2; 300 injections in 1000 cycles.
- Credit exhaustion: BUFFER_DEPTH=4, no credit_in -> 4 injections, then stall=1 and FSM=STALL. A single credit_in pulse -> exactly one further injection, then stall again.
- Simultaneous inject + credit_in with credits=2 -> credits remain 2. credit_in at credits=4 -> remains 4.
- Enable drop: deassert enable mid-stream -> no req_ack in that cycle or after. The last granted packet still appears on channel_valid one cycle later. slot resets to 0 in IDLE.
- Reset mid-operation: assert reset while credits=1 and a grant is in flight -> next cycle channel_valid=0, credits=4, rr_ptr=0. The first post-reset grant goes to requester 0.
